spi_sts_fault_sequencer: RTL and testbench

Fault-event sequencer for the AXI-domain side of the SPI status path. It takes the ten synchronized 8-channel status vectors and captures every rising fault bit into sticky and pending registers. It serializes pending faults into one event stream with a valid/ready handshake, and drives a shutdown request and an interrupt level. Software clears all fault state through a request/acknowledge handshake.

---
 rtl/spi_sts_fault_sequencer.sv | 123 ++++++++++++
 tb/tb_spi_sts_fault_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sts_fault_sequencer.sv
// rtl/spi_sts_fault_sequencer.sv - sticky fault capture and round-robin event sequencer
// Optional feature macro: SPI_STS_TIMESTAMP_EN (timestamp counter in event bits [23:0]).
`timescale 1ns/1ps
module spi_sts_fault_sequencer #(
  parameter int TS_WIDTH = 24
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        spi_off_stable,
  input  logic [79:0] status_vec,
  input  logic        clr_req,
  output logic        clr_ack,
  output logic [31:0] m_evt_data,
  output logic        m_evt_valid,
  input  logic        m_evt_ready,
  output logic        shutdown_req,
  output logic        irq,
  output logic [79:0] sticky
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [6:0]  ptr_q, ptr_d, ptr_inc;
  logic [79:0] sticky_q, sticky_d, pending_q, pending_d, cap;
  logic        first_q, first_d;
  logic [31:0] data_q, data_d;
  logic        clr_ack_q, shutdown_q, irq_q, clr_take;
  logic [23:0] ts_ext;

`ifdef SPI_STS_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) ts_q <= '0;
    else        ts_q <= ts_q + TS_WIDTH'(1);
  end
  assign ts_ext = 24'(ts_q);
`else
  logic [TS_WIDTH-1:0] ts_zero;
  assign ts_zero = '0;
  assign ts_ext  = 24'(ts_zero);
`endif

  // A request held through the ack cycle must not restart a second clear.
  assign clr_take = clr_req & ~clr_ack_q;
  assign cap      = spi_off_stable ? '0 : status_vec;
  assign ptr_inc  = (ptr_q == 7'd79) ? 7'd0 : ptr_q + 7'd1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    data_d    = data_q;
    sticky_d  = sticky_q | cap;
    pending_d = pending_q | (cap & ~sticky_q);
    case (state_q)
      IDLE: begin
        if (clr_take)         state_d = CLEAR;
        else if (|pending_q)  state_d = SCAN;
      end
      SCAN: begin
        if (clr_take) begin
          state_d = CLEAR;
        end else if (pending_q[ptr_q]) begin
          data_d             = {ptr_q[6:3], ptr_q[2:0], first_q, ts_ext};
          pending_d[ptr_q]   = 1'b0;
          first_d            = 1'b0;
          state_d            = EMIT;
        end else begin
          ptr_d = ptr_inc;
          if (pending_q == '0) state_d = IDLE;
        end
      end
      EMIT: begin
        if (m_evt_ready) begin
          ptr_d   = ptr_inc;
          state_d = clr_take ? CLEAR : SCAN;
        end
      end
      CLEAR: begin
        // Faults present during the clear cycle survive it.
        sticky_d  = cap;
        pending_d = cap;
        ptr_d     = 7'd0;
        first_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sticky_q   <= '0;
      pending_q  <= '0;
      first_q    <= 1'b1;
      data_q     <= '0;
      clr_ack_q  <= 1'b0;
      shutdown_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sticky_q   <= sticky_d;
      pending_q  <= pending_d;
      first_q    <= first_d;
      data_q     <= data_d;
      clr_ack_q  <= (state_q == CLEAR);
      shutdown_q <= |sticky_q;
      irq_q      <= (|pending_q) | (state_q == EMIT);
    end
  end

  assign clr_ack      = clr_ack_q;
  assign m_evt_data   = data_q;
  assign m_evt_valid  = (state_q == EMIT);
  assign shutdown_req = shutdown_q;
  assign irq          = irq_q;
  assign sticky       = sticky_q;

endmodule

// File: tb/tb_spi_sts_fault_sequencer.sv
// tb/tb_spi_sts_fault_sequencer.sv - randomized self-checking bench for spi_sts_fault_sequencer
`timescale 1ns/1ps
module tb_spi_sts_fault_sequencer;
  localparam int TSW = 8;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic        spi_off_stable = 1'b0;
  logic [79:0] status_vec = '0;
  logic        clr_req = 1'b0;
  logic        m_evt_ready = 1'b0;
  logic        clr_ack, m_evt_valid, shutdown_req, irq;
  logic [31:0] m_evt_data;
  logic [79:0] sticky;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic last_valid = 1'b0;

  bit [79:0] m_sticky, m_pend;
  int        m_ptr;
  bit        m_first;

  spi_sts_fault_sequencer #(.TS_WIDTH(TSW)) dut (
    .aclk(aclk), .areset(areset), .spi_off_stable(spi_off_stable),
    .status_vec(status_vec), .clr_req(clr_req), .clr_ack(clr_ack),
    .m_evt_data(m_evt_data), .m_evt_valid(m_evt_valid), .m_evt_ready(m_evt_ready),
    .shutdown_req(shutdown_req), .irq(irq), .sticky(sticky)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk or posedge areset) begin
    if (areset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    last_valid = m_evt_valid;
    @(posedge aclk);
    #1;
  endtask

  function automatic void model_reset();
    m_sticky = '0; m_pend = '0; m_ptr = 0; m_first = 1'b1;
  endfunction

  function automatic int model_find();
    for (int k = 0; k < 80; k++) if (m_pend[(m_ptr + k) % 80]) return (m_ptr + k) % 80;
    return 0;
  endfunction

  function automatic logic [7:0] hdr_of(input int b, input bit first);
    return {4'(b / 8), 3'(b % 8), first};
  endfunction

  task automatic apply(input logic [79:0] v);
    status_vec = v;
    if (!spi_off_stable) begin
      m_pend   = m_pend | (v & ~m_sticky);
      m_sticky = m_sticky | v;
    end
    tick();
    status_vec = '0;
  endtask

  // mode 0: ready always high; 1: random ready; 2: hold ready low 10 cycles per event
  task automatic run_events(input int mode);
    int n_exp = $countones(m_pend);
    int got = 0, stall = 0, b = 0, last_b = -10, last_seen = 0;
    bit inflight = 0, r;
    logic [31:0] held = '0;
    for (int c = 0; c < 300 + 60 * n_exp && got < n_exp; c++) begin
      if (m_evt_valid) begin
        if (!inflight) begin
          b = model_find();
          check("evt_hdr", m_evt_data[31:24], hdr_of(b, m_first));
`ifdef SPI_STS_TIMESTAMP_EN
          if (!last_valid) check("evt_ts", m_evt_data[23:0], 24'((cyc - 1) & ((1 << TSW) - 1)));
`else
          check("evt_ts", m_evt_data[23:0], 24'd0);
`endif
          if (mode == 0 && b == last_b + 1) check("b2b_gap", cyc - last_seen, 2);
          last_b = b; last_seen = cyc;
          m_pend[b] = 1'b0; m_first = 1'b0; m_ptr = (b + 1) % 80;
          inflight = 1; held = m_evt_data; stall = 0;
        end else begin
          check("evt_stable", m_evt_data, held);
        end
      end else if (inflight) begin
        check("valid_held", m_evt_valid, 1);
      end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 2) != 0) : (stall >= 10);
      m_evt_ready = r;
      if (inflight && m_evt_valid && r) begin inflight = 0; got++; end
      else if (inflight) stall++;
      tick();
    end
    check("evt_count", got, n_exp);
    if (got > 0) m_ptr = (m_ptr + 1) % 80;
  endtask

  task automatic settle();
    m_evt_ready = 1'b1;
    repeat (3) tick();
    check("idle_valid", m_evt_valid, 0);
    check("idle_irq", irq, 0);
    check("sticky", sticky, m_sticky);
    check("shutdown", shutdown_req, |m_sticky);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m_evt_valid && n < 200) begin tick(); n++; end
    check("wait_valid", m_evt_valid, 1);
  endtask

  // Entered just after the edge that sampled clr_req; v is driven during the CLEAR cycle.
  task automatic clear_tail(input logic [79:0] v);
    status_vec = v;
    tick();
    status_vec = '0;
    check("ack_pulse", clr_ack, 1);
    m_sticky = spi_off_stable ? '0 : v; m_pend = m_sticky; m_ptr = 0; m_first = 1'b1;
    check("clr_sticky", sticky, m_sticky);
    tick();
    check("ack_one_cycle", clr_ack, 0);
    clr_req = 1'b0;
    tick();
    check("ack_no_repeat", clr_ack, 0);
  endtask

  task automatic do_clear(input logic [79:0] v);
    clr_req = 1'b1;
    tick();
    check("ack_early", clr_ack, 0);
    clear_tail(v);
  endtask

  initial begin
    logic [79:0] v;
    int b;
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    model_reset();
    check("rst_valid", m_evt_valid, 0);
    check("rst_data", m_evt_data, 0);
    check("rst_sticky", sticky, 0);
    check("rst_shutdown", shutdown_req, 0);
    check("rst_irq", irq, 0);
    check("rst_ack", clr_ack, 0);

    // single fault on bit 19 with capture latency
    m_evt_ready = 1'b1;
    v = '0; v[19] = 1'b1;
    apply(v);
    check("cap_sticky", sticky, m_sticky);
    check("cap_shutdown_lag", shutdown_req, 0);
    check("cap_irq_lag", irq, 0);
    tick();
    check("cap_shutdown", shutdown_req, 1);
    check("cap_irq", irq, 1);
    run_events(0);
    settle();

    // burst 79/0/40 from ptr 0 with backpressure
    do_clear('0);
    m_evt_ready = 1'b0;
    v = '0; v[79] = 1'b1; v[0] = 1'b1; v[40] = 1'b1;
    apply(v);
    tick();
    check("lat1_valid", m_evt_valid, 0);
    tick();
    check("lat2_valid", m_evt_valid, 1);
    run_events(2);
    settle();

    // adjacent bits stream every 2 cycles
    do_clear('0);
    v = '0; v[20] = 1'b1; v[21] = 1'b1; v[22] = 1'b1;
    apply(v);
    run_events(0);
    settle();

    // sticky suppression: hold then toggle bit 5
    m_evt_ready = 1'b0;
    v = '0; v[5] = 1'b1;
    for (int i = 0; i < 100; i++) apply(v);
    for (int i = 0; i < 20; i++) apply((i % 2) ? v : '0);
    run_events(0);
    settle();

    // clear raised during EMIT, plain and with a fault in the CLEAR cycle
    for (int pass = 0; pass < 2; pass++) begin
      do_clear('0);
      m_evt_ready = 1'b0;
      v = '0; v[33] = 1'b1;
      apply(v);
      wait_valid();
      b = model_find();
      check("emit_hdr", m_evt_data[31:24], hdr_of(b, m_first));
      clr_req = 1'b1;
      tick(); tick();
      check("emit_kept", m_evt_valid, 1);
      check("emit_no_ack", clr_ack, 0);
      m_evt_ready = 1'b1;
      tick();
      m_evt_ready = 1'b0;
      check("emit_done", m_evt_valid, 0);
      check("emit_ack_early", clr_ack, 0);
      v = '0;
      if (pass == 1) v[8] = 1'b1;
      clear_tail(v);
      run_events(0);
      settle();
    end

    // SPI off: nothing captured
    do_clear('0);
    settle();
    spi_off_stable = 1'b1;
    for (int i = 0; i < 5; i++) apply({80{1'b1}});
    check("off_valid", m_evt_valid, 0);
    spi_off_stable = 1'b0;
    settle();

    // asynchronous reset while an event is in flight
    m_evt_ready = 1'b0;
    v = '0; v[50] = 1'b1;
    apply(v);
    wait_valid();
    #2 areset = 1'b1;
    #1;
    check("arst_valid", m_evt_valid, 0);
    check("arst_data", m_evt_data, 0);
    check("arst_sticky", sticky, 0);
    check("arst_shutdown", shutdown_req, 0);
    check("arst_irq", irq, 0);
    check("arst_ack", clr_ack, 0);
    @(posedge aclk);
    #1 areset = 1'b0;
    model_reset();
    m_evt_ready = 1'b1;
    v = '0; v[3] = 1'b1;
    apply(v);
    run_events(0);
    settle();

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int r = $urandom_range(0, 9);
      if (r < 7) begin
        v = '0;
        for (int k = 0; k < $urandom_range(1, 5); k++) v[$urandom_range(0, 79)] = 1'b1;
        apply(v);
        run_events(1);
      end else if (r < 9) begin
        v = '0;
        if ($urandom_range(0, 1) != 0) v[$urandom_range(0, 79)] = 1'b1;
        do_clear(v);
        run_events(1);
      end else begin
        spi_off_stable = 1'b1;
        v = '0;
        v[$urandom_range(0, 79)] = 1'b1;
        apply(v);
        spi_off_stable = 1'b0;
      end
      settle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
